// File: rtl/disp_scan_hm.sv
// Multiplexed 4-digit BCD seven-segment scanner with frame-synchronous display updates,
// leading-zero blanking and per-digit decimal points.
module disp_scan_hm #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [15:0] data,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  dp_sel,
    output logic [2:0]  a,
    output logic [6:0]  seg_l,
    output logic        dp_l,
    output logic        tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [2:0]    a_reg;
    logic [2:0]    a_next;
    logic          tick_reg;
    logic [15:0]   pending_reg;
    logic [15:0]   display_reg;
    logic          adv;
    logic          wrap;

    assign adv = (cnt_reg == CNT_MAX);

    // Mode 1 stops at digit 2; any index beyond the last visible digit folds back to 0.
    always_comb begin
        a_next = a_reg;
        if (mode) begin
            a_next = (a_reg >= 3'd2) ? 3'd0 : a_reg + 3'd1;
        end else begin
            a_next = (a_reg >= 3'd3) ? 3'd0 : a_reg + 3'd1;
        end
    end

    assign wrap = adv && (a_next == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg     <= '0;
            a_reg       <= 3'd0;
            tick_reg    <= 1'b0;
            pending_reg <= 16'h0000;
            display_reg <= 16'h0000;
        end else begin
            cnt_reg  <= adv ? '0 : cnt_reg + 1'b1;
            tick_reg <= adv;
            if (adv) begin
                a_reg <= a_next;
            end
            if (load) begin
                pending_reg <= data;
            end
            // A load coinciding with the frame boundary goes straight to the display.
            if (wrap) begin
                display_reg <= load ? data : pending_reg;
            end
        end
    end

    assign a    = a_reg;
    assign tick = tick_reg;

    logic [3:0] nib [4];
    logic [3:0] nz;
    logic [3:0] zero_from;

    // zero_from[k]: digit k and every visible digit above it hold zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            assign nib[gi] = display_reg[4*gi +: 4];
            if (gi == 3) begin : g_top
                assign nz[gi]        = (nib[gi] != 4'd0) && !mode;
                assign zero_from[gi] = !nz[gi];
            end else begin : g_low
                assign nz[gi]        = (nib[gi] != 4'd0);
                assign zero_from[gi] = !nz[gi] && zero_from[gi+1];
            end
        end
    endgenerate

    logic [1:0] sel;
    logic [3:0] cur_nib;
    logic       blank;
    logic [6:0] glyph;

    assign sel     = a_reg[1:0];
    assign cur_nib = nib[sel];
    assign blank   = blank_lz && (sel != 2'd0) && zero_from[sel];

    always_comb begin
        glyph = 7'b0111111;
        case (cur_nib)
            4'd0:    glyph = 7'b1000000;
            4'd1:    glyph = 7'b1111001;
            4'd2:    glyph = 7'b0100100;
            4'd3:    glyph = 7'b0110000;
            4'd4:    glyph = 7'b0011001;
            4'd5:    glyph = 7'b0010010;
            4'd6:    glyph = 7'b0000010;
            4'd7:    glyph = 7'b1111000;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0010000;
            default: glyph = 7'b0111111;
        endcase
    end

    assign seg_l = blank ? 7'b1111111 : glyph;
    assign dp_l  = !dp_sel[sel];

endmodule

// File: doc/disp_scan_hm.md
DISP_SCAN_HM -- requirements
Module: disp_scan_hm

Interface
REQ-001: Parameter REFRESH_DIV, default 100000, clocks per digit dwell (1 kHz digit rate at 100 MHz); SHALL be >= 2.
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003: rst  input  1  reset, synchronous, active-high.
REQ-004: mode  input  1  0 = reaction timer (4 digits), 1 = pulse monitor (3 digits).
REQ-005: data  input  16  four BCD nibbles; nibble k (bits 4k+3:4k) is digit k; digit 0 is rightmost.
REQ-006: load  input  1  one-cycle strobe capturing data into the pending register.
REQ-007: blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-008: dp_sel  input  4  per-digit decimal point enable; bit k applies to digit k.
REQ-009: a  output  3  registered digit index driving the downstream anode decoder.
REQ-010: seg_l  output  7  active-low segments, bit order {g,f,e,d,c,b,a} (bit 6 = g).
REQ-011: dp_l  output  1  active-low decimal point.
REQ-012: tick  output  1  registered one-cycle digit-advance pulse.

Function
REQ-013: Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; tick SHALL be 1 in the cycle after cnt = REFRESH_DIV-1, else 0.
REQ-014: a SHALL change only on the edge where tick is generated (same edge tick rises), so a holds each value exactly REFRESH_DIV cycles.
REQ-015: Digit order: mode 0 -> 0,1,2,3,0...; mode 1 -> 0,1,2,0...
REQ-016: If mode = 1 while a = 3 (mode switch), next advance SHALL set a = 0; a SHALL never exceed 3.
REQ-017: load = 1 SHALL write data into pending at that edge; later loads overwrite earlier ones.
REQ-018: Frame boundary = advance edge where a wraps to 0; at it, display register SHALL take data if load = 1 that cycle (bypass), else pending.
REQ-019: Display register SHALL change only at frame boundaries (no tearing within a frame).
REQ-020: seg_l and dp_l SHALL be combinational functions of registered a, display, mode, blank_lz, dp_sel only, so they are consistent with a every cycle.
REQ-021: Nibble n = display bits 4a+3:4a; values 0-9 SHALL decode to standard glyphs (0 = 7'b1000000, 4 = 7'b0011001, 5 = 7'b0010010); values 10-15 SHALL show dash seg_l = 7'b0111111.
REQ-022: Blanking: with blank_lz = 1, digit a > 0 SHALL show seg_l = 7'b1111111 when its nibble and every nibble above it up to the top visible digit (3 in mode 0, 2 in mode 1) are 0; digit 0 is never blanked.
REQ-023: dp_l SHALL equal ~dp_sel[a]; blanking does not suppress dp.
REQ-024: In mode 1 digit 3 nibble SHALL be ignored for blanking.

Reset
REQ-025: rst = 1 SHALL force cnt = 0, a = 0, tick = 0, pending = 0, display = 0 at the next edge, overriding load and advance that cycle.
REQ-026: Out of reset, digit 0 SHALL show seg_l = 7'b1000000; first advance SHALL occur REFRESH_DIV cycles after rst deasserts.
REQ-027: Reset mid-frame SHALL discard pending data and restart the scan at digit 0.

Verification (REFRESH_DIV = 4)
REQ-028: Reset, mode 0, run 20 cycles -> a = 0,1,2,3,0 each held 4 cycles; tick high exactly on the 4 advance cycles.
REQ-029: mode 1 -> a = 0,1,2,0; switch mode 0->1 while a = 3 -> next advance gives a = 0.
REQ-030: load 16'h1234 while a = 1 -> seg_l unchanged until wrap; after wrap digit 0 shows 7'b0011001 (4).
REQ-031: blank_lz = 1, mode 0, display 16'h0050 -> digits 3,2 seg_l = 7'b1111111, digit 1 = 7'b0010010, digit 0 = 7'b1000000.
REQ-032: display 16'h000A, dp_sel = 4'b1000 -> digit 0 seg_l = 7'b0111111; dp_l = 0 only while a = 3.
REQ-033: rst and load 16'hFFFF in the same cycle mid-frame -> next cycle a = 0, cnt = 0, display = 0; FFFF never displayed.
